tone_period_meter: RTL and testbench
====================================

# tone_period_meter

Tone period measurement block: the receive-side counterpart of the buzzer/tone PWM generator. It synchronises an external square wave and measures the clk-cycle distance between consecutive rising edges and the high time. It also converts the period into the generator's 20-bit half-period parameter, so a tone can be measured and replayed, or a generator output looped back for self-check. It sits on the peripheral bus side as a read-only capture unit with a one-cycle result strobe.

## Interface
- CNT_W, 21: width of the period/high-time counters; minimum 3
- SYNC_STAGES, 2: synchroniser flops on sig_in; minimum 2
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- en  input  1  measurement enable; low forces IDLE
- sig_in  input  1  asynchronous square-wave input
- period_raw  output  CNT_W  clk cycles between the last two rising edges
- high_cycles  output  CNT_W  clk cycles from rising edge to falling edge, last period
- tune_param  output  20  generator parameter equivalent, (period_raw>>1)-1, clamped
- valid  output  1  one-cycle strobe; results updated
- timeout  output  1  sticky flag; no rising edge within 2^CNT_W-1 cycles
- busy  output  1  high when state is not IDLE

## Operation
- Synchroniser: SYNC_STAGES flops followed by one history flop; all reset to 0.
  - rise = sync_out & ~hist
  - fall = ~sync_out & hist
- Edge detection runs regardless of state. The synchroniser never holds X.
- States: IDLE, ARM, MEAS. Reset state is IDLE.
- IDLE:
  - cnt=0, valid=0.
  - en=1 -> ARM on the next edge. timeout is cleared on entry to ARM from IDLE.
- ARM:
  - Wait for rise. On rise: cnt<=1, hi_tmp<=0, go MEAS. No valid is generated for the first edge.
  - No timeout is counted in ARM.
- MEAS, evaluated each cycle with priority top-down:
  - en=0 -> IDLE.
  - rise -> capture and restart:
    - period_raw<=cnt
    - high_cycles<=hi_tmp
    - tune_param<=conv(cnt)
    - valid<=1, timeout<=0
    - cnt<=1, hi_tmp<=0; stay MEAS
  - cnt==2^CNT_W-1 -> timeout<=1, cnt<=0, go ARM. Result registers are unchanged.
  - Otherwise cnt<=cnt+1. If fall, also hi_tmp<=cnt.
- conv(n):
  - n<2 -> 0
  - else (n>>1)-1; if that exceeds 20'hFFFFF -> 20'hFFFFF
  - Odd n truncates (floor).
- Generator relation: a generator with parameter P produces a period of 2*(P+1) cycles, so conv recovers P exactly.
- en falling at any time:
  - Next state is IDLE; the partial measurement is discarded; valid is not asserted.
  - period_raw/high_cycles/tune_param hold their last values. timeout holds until the next ARM entry.
- Simultaneous rise with cnt at all-ones: rise wins and a valid capture is made.
- rise and fall cannot occur in the same cycle.

## Timing
- Reset values: period_raw=0, high_cycles=0, tune_param=0, valid=0, timeout=0, busy=0, cnt=0, hi_tmp=0.
- Latency from sig_in sampled high at edge k (SYNC_STAGES=2): rise is visible in the cycle after edge k+1; valid and results are updated at edge k+2.
  - Generally SYNC_STAGES+1 edges.
- valid:
  - High for exactly one cycle per captured period.
  - Outputs change on the same edge that valid rises, and are stable until the next valid.
- Result accuracy: period_raw equals the exact cycle count between synchronised rising edges; jitter is at most ±1 cycle per edge relative to the asynchronous sig_in.
- Minimum measurable period is 2 cycles (sig_in toggling every cycle): period_raw=2, high_cycles=1.
- Timeout fires 2^CNT_W-1 cycles after the last rise. timeout goes high on that edge and the state is ARM on the following cycle.
- busy is registered state decode: high from the edge after en is sampled high until the edge after en is sampled low.

## Test plan
- Measure a reference tone:
  - Stimulus: rst, en=1, drive a generator-style wave with P=99 (100 high, 100 low), 4 periods.
  - Response: 3 valid strobes; period_raw=200, high_cycles=100, tune_param=99.
- Asymmetric duty, odd period:
  - Stimulus: 37 cycles high, 64 low.
  - Response: period_raw=101, high_cycles=37, tune_param=49.
- Fastest input:
  - Stimulus: sig_in toggling every clk.
  - Response: period_raw=2, high_cycles=1, tune_param=0; valid every 2 cycles.
- Timeout with CNT_W=8:
  - Stimulus: one rise, then sig_in held high.
  - Response: timeout=1 255 cycles after that rise, state ARM, outputs unchanged.
  - Follow-up: the next 2 rises give one valid and clear timeout.
- en dropped mid-period:
  - Stimulus: P=99 wave, en low for 5 cycles at cycle 50 of a period, then high.
  - Response: no valid for the broken period; busy low for those cycles; old results held; next valid only after two fresh rises.
- Reset mid-measurement:
  - Stimulus: assert rst_n low asynchronously during MEAS.
  - Response: all outputs 0 immediately; after release with en=1, the first valid comes only after two fresh rising edges.

Source files
------------

// File: rtl/tone_period_meter.sv
// Tone period meter: synchronises a square wave and measures the rise-to-rise period and high time,
// then converts the period into the matching tone generator half-period parameter.
module tone_period_meter #(
  parameter int CNT_W       = 21,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             sig_in_i,
  output logic [CNT_W-1:0] period_raw_o,
  output logic [CNT_W-1:0] high_cycles_o,
  output logic [19:0]      tune_param_o,
  output logic             valid_o,
  output logic             timeout_o,
  output logic             busy_o
);

  localparam int EXT_W = (CNT_W > 20) ? CNT_W : 20;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [EXT_W-1:0] CONV_MAX = EXT_W'(20'hFFFFF);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_MEAS = 2'd2
  } state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       hi_tmp_q;
  logic [CNT_W-1:0]       period_q;
  logic [CNT_W-1:0]       high_q;
  logic [19:0]            tune_q;
  logic                   valid_q;
  logic                   timeout_q;
  logic                   busy_q;
  logic                   rise_s;
  logic                   fall_s;

  // Period n corresponds to generator parameter floor(n/2)-1, saturated to 20 bits
  function automatic logic [19:0] conv(input logic [CNT_W-1:0] n);
    logic [EXT_W-1:0] half;
    logic [EXT_W-1:0] minus1;
    logic [19:0]      res;
    half   = EXT_W'(n >> 1);
    minus1 = half - EXT_W'(1'b1);
    if (n < CNT_W'(2'd2)) begin
      res = 20'd0;
    end else if (minus1 > CONV_MAX) begin
      res = 20'hFFFFF;
    end else begin
      res = 20'(minus1);
    end
    return res;
  endfunction

  assign rise_s = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign fall_s = ~sync_q[SYNC_STAGES-1] & hist_q;

  // Input synchroniser chain plus history flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{1'b0}};
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Measurement FSM with registered results, strobe, timeout and busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      hi_tmp_q  <= {CNT_W{1'b0}};
      period_q  <= {CNT_W{1'b0}};
      high_q    <= {CNT_W{1'b0}};
      tune_q    <= 20'd0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= {CNT_W{1'b0}};
          if (en_i) begin
            state_q   <= ST_ARM;
            busy_q    <= 1'b1;
            timeout_q <= 1'b0;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_ARM: begin
          if (!en_i) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (rise_s) begin
            cnt_q    <= CNT_W'(1'b1);
            hi_tmp_q <= {CNT_W{1'b0}};
            state_q  <= ST_MEAS;
            busy_q   <= 1'b1;
          end else begin
            state_q <= ST_ARM;
            busy_q  <= 1'b1;
          end
        end
        ST_MEAS: begin
          if (!en_i) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (rise_s) begin
            // A rise wins over a simultaneous counter overflow
            period_q  <= cnt_q;
            high_q    <= hi_tmp_q;
            tune_q    <= conv(cnt_q);
            valid_q   <= 1'b1;
            timeout_q <= 1'b0;
            cnt_q     <= CNT_W'(1'b1);
            hi_tmp_q  <= {CNT_W{1'b0}};
            state_q   <= ST_MEAS;
            busy_q    <= 1'b1;
          end else if (cnt_q == CNT_MAX) begin
            timeout_q <= 1'b1;
            cnt_q     <= {CNT_W{1'b0}};
            state_q   <= ST_ARM;
            busy_q    <= 1'b1;
          end else begin
            cnt_q   <= cnt_q + CNT_W'(1'b1);
            state_q <= ST_MEAS;
            busy_q  <= 1'b1;
            if (fall_s) begin
              hi_tmp_q <= cnt_q;
            end else begin
              hi_tmp_q <= hi_tmp_q;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= {CNT_W{1'b0}};
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign period_raw_o  = period_q;
  assign high_cycles_o = high_q;
  assign tune_param_o  = tune_q;
  assign valid_o       = valid_q;
  assign timeout_o     = timeout_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_tone_period_meter.sv
// Directed bench for tone_period_meter (CNT_W=8): reference tone, odd period, fastest input,
// timeout, enable drop and asynchronous reset.
module tb_tone_period_meter;

  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             sig;
  logic [CNT_W-1:0] period_raw;
  logic [CNT_W-1:0] high_cycles;
  logic [19:0]      tune_param;
  logic             valid;
  logic             timeout;
  logic             busy;

  int n_cmp = 0;
  int n_err = 0;
  int vcnt  = 0;
  int v0    = 0;

  tone_period_meter #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_i         (en),
    .sig_in_i     (sig),
    .period_raw_o (period_raw),
    .high_cycles_o(high_cycles),
    .tune_param_o (tune_param),
    .valid_o      (valid),
    .timeout_o    (timeout),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts cycles in which the strobe is high, sampled away from the active edge
  always @(negedge clk) begin
    if (valid === 1'b1) vcnt <= vcnt + 1;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wave(input int hi, input int lo, input int periods);
    for (int i = 0; i < periods; i++) begin
      sig = 1'b1;
      tick(hi);
      sig = 1'b0;
      tick(lo);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    sig   = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    chk("rst_period", 32'(period_raw), 32'd0);
    chk("rst_high", 32'(high_cycles), 32'd0);
    chk("rst_tune", 32'(tune_param), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Reference tone P=99
    en = 1'b1;
    tick(3);
    chk("busy_on", 32'(busy), 32'd1);
    wave(100, 100, 4);
    chk("ref_valids", 32'(vcnt), 32'd3);
    chk("ref_period", 32'(period_raw), 32'd200);
    chk("ref_high", 32'(high_cycles), 32'd100);
    chk("ref_tune", 32'(tune_param), 32'd99);

    // Asymmetric duty, odd period
    v0 = vcnt;
    wave(37, 64, 3);
    chk("odd_valids", 32'(vcnt - v0), 32'd3);
    chk("odd_period", 32'(period_raw), 32'd101);
    chk("odd_high", 32'(high_cycles), 32'd37);
    chk("odd_tune", 32'(tune_param), 32'd49);

    // Fastest input: toggling every clock
    v0 = vcnt;
    wave(1, 1, 10);
    tick(5);
    chk("fast_valids", 32'(vcnt - v0), 32'd10);
    chk("fast_period", 32'(period_raw), 32'd2);
    chk("fast_high", 32'(high_cycles), 32'd1);
    chk("fast_tune", 32'(tune_param), 32'd0);

    // One rise then held high: capture of a 7-cycle period, then timeout
    v0 = vcnt;
    sig = 1'b1;
    tick(5);
    chk("to_cap_valid", 32'(vcnt - v0), 32'd1);
    chk("to_cap_period", 32'(period_raw), 32'd7);
    chk("to_cap_high", 32'(high_cycles), 32'd1);
    chk("to_cap_tune", 32'(tune_param), 32'd2);
    tick(245);
    chk("to_early", 32'(timeout), 32'd0);
    tick(12);
    chk("to_set", 32'(timeout), 32'd1);
    chk("to_busy", 32'(busy), 32'd1);
    chk("to_hold_period", 32'(period_raw), 32'd7);
    chk("to_no_valid", 32'(vcnt - v0), 32'd1);

    // Two fresh rises after timeout: one capture, timeout cleared
    v0 = vcnt;
    sig = 1'b0;
    tick(10);
    wave(10, 10, 2);
    tick(5);
    chk("rearm_valids", 32'(vcnt - v0), 32'd1);
    chk("rearm_period", 32'(period_raw), 32'd20);
    chk("rearm_high", 32'(high_cycles), 32'd10);
    chk("rearm_tune", 32'(tune_param), 32'd9);
    chk("rearm_timeout", 32'(timeout), 32'd0);

    // Enable dropped mid-period
    wave(100, 100, 2);
    sig = 1'b1;
    tick(50);
    chk("en_pre_period", 32'(period_raw), 32'd200);
    v0 = vcnt;
    en = 1'b0;
    tick(2);
    chk("en_busy_low", 32'(busy), 32'd0);
    tick(3);
    en = 1'b1;
    tick(45);
    sig = 1'b0;
    tick(100);
    chk("en_broken_valid", 32'(vcnt - v0), 32'd0);
    chk("en_hold_period", 32'(period_raw), 32'd200);
    chk("en_hold_high", 32'(high_cycles), 32'd100);
    chk("en_busy_back", 32'(busy), 32'd1);
    wave(60, 40, 1);
    chk("en_arm_valid", 32'(vcnt - v0), 32'd0);
    wave(60, 40, 1);
    chk("en_new_valid", 32'(vcnt - v0), 32'd1);
    chk("en_new_period", 32'(period_raw), 32'd100);
    chk("en_new_high", 32'(high_cycles), 32'd60);
    chk("en_new_tune", 32'(tune_param), 32'd49);

    // Asynchronous reset during MEAS
    sig = 1'b1;
    tick(30);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_period", 32'(period_raw), 32'd0);
    chk("ar_high", 32'(high_cycles), 32'd0);
    chk("ar_tune", 32'(tune_param), 32'd0);
    chk("ar_valid", 32'(valid), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    tick(2);
    sig   = 1'b0;
    rst_n = 1'b1;
    tick(3);
    v0 = vcnt;
    wave(30, 30, 1);
    chk("ar_first_valid", 32'(vcnt - v0), 32'd0);
    chk("ar_busy_on", 32'(busy), 32'd1);
    wave(30, 30, 1);
    chk("ar_second_valid", 32'(vcnt - v0), 32'd1);
    chk("ar_new_period", 32'(period_raw), 32'd60);
    chk("ar_new_high", 32'(high_cycles), 32'd30);
    chk("ar_new_tune", 32'(tune_param), 32'd29);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
